// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit: sequences fetch, decode, execute, memory and writeback,
// drives every datapath enable/select and traps on illegal opcodes or memory timeouts.
module mc_control_fsm #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       oldpc_we,
  output logic       ir_we,
  output logic       mdr_we,
  output logic       mem_en,
  output logic       mem_wr,
  output logic       mem_addr_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_sel,
  output logic       instr_retired,
  output logic       halted,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_EXEC_U   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_ALU_WB   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t     state_q;
  state_t     state_next;
  logic [1:0] cause_q;
  logic [1:0] cause_next;
  logic [7:0] wait_cnt;
  logic       in_wait_state;
  logic       wait_expired;
  logic       branch_taken;

  assign state      = state_q;
  assign trap_cause = cause_q;
  assign halted     = (state_q == S_TRAP);

  // A memory wait expires when the counter sits on its last allowed value with no ready;
  // a ready on that same cycle still completes the access.
  assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign wait_expired  = in_wait_state && !mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = alu_zero;
      3'b001:  branch_taken = !alu_zero;
      3'b100:  branch_taken = alu_lt;
      3'b101:  branch_taken = !alu_lt;
      3'b110:  branch_taken = alu_ltu;
      3'b111:  branch_taken = !alu_ltu;
      default: branch_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      cause_q  <= 2'd0;
      wait_cnt <= 8'd0;
    end else begin
      state_q <= state_next;
      cause_q <= cause_next;
      if (state_next != state_q) begin
        wait_cnt <= 8'd0;
      end else if (in_wait_state && !mem_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_next    = state_q;
    cause_next    = cause_q;
    pc_we         = 1'b0;
    pc_src        = 2'd0;
    oldpc_we      = 1'b0;
    ir_we         = 1'b0;
    mdr_we        = 1'b0;
    mem_en        = 1'b0;
    mem_wr        = 1'b0;
    mem_addr_sel  = 1'b0;
    rf_we         = 1'b0;
    wb_sel        = 2'd0;
    alu_src_a     = 2'd0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    imm_sel       = IMM_I;
    instr_retired = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_en = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          oldpc_we   = 1'b1;
          pc_we      = 1'b1;
          state_next = S_DECODE;
        end else if (wait_expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      // ALUOut captures oldPC+imm here so branch/JAL targets are ready one cycle later.
      S_DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        case (opcode)
          OP_STORE:        imm_sel = IMM_S;
          OP_BRANCH:       imm_sel = IMM_B;
          OP_LUI, OP_AUIPC: imm_sel = IMM_U;
          OP_JAL:          imm_sel = IMM_J;
          default:         imm_sel = IMM_I;
        endcase
        case (opcode)
          OP_R:              state_next = S_EXEC_R;
          OP_IMM:            state_next = S_EXEC_I;
          OP_LUI, OP_AUIPC:  state_next = S_EXEC_U;
          OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
          OP_BRANCH: begin
            if (funct3 == 3'b010 || funct3 == 3'b011) begin
              state_next = S_TRAP;
              cause_next = CAUSE_ILLEGAL;
            end else begin
              state_next = S_BRANCH;
            end
          end
          OP_JAL:  state_next = S_JAL;
          OP_JALR: state_next = S_JALR;
          default: begin
            state_next = S_TRAP;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end

      S_EXEC_R: begin
        alu_op     = 2'd2;
        state_next = S_ALU_WB;
      end

      S_EXEC_I: begin
        alu_src_b  = 2'd1;
        alu_op     = 2'd3;
        state_next = S_ALU_WB;
      end

      S_EXEC_U: begin
        alu_src_a  = (opcode == OP_LUI) ? 2'd2 : 2'd1;
        alu_src_b  = 2'd1;
        imm_sel    = IMM_U;
        state_next = S_ALU_WB;
      end

      S_ALU_WB: begin
        rf_we         = 1'b1;
        instr_retired = 1'b1;
        state_next    = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_b  = 2'd1;
        imm_sel    = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_en       = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready) begin
          mdr_we     = 1'b1;
          state_next = S_MEM_WB;
        end else if (wait_expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      S_MEM_WB: begin
        rf_we         = 1'b1;
        wb_sel        = 2'd1;
        instr_retired = 1'b1;
        state_next    = S_FETCH;
      end

      S_MEM_WR: begin
        mem_en       = 1'b1;
        mem_wr       = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready) begin
          instr_retired = 1'b1;
          state_next    = S_FETCH;
        end else if (wait_expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      S_BRANCH: begin
        alu_op        = 2'd1;
        instr_retired = 1'b1;
        state_next    = S_FETCH;
        if (branch_taken) begin
          pc_we  = 1'b1;
          pc_src = 2'd1;
        end
      end

      S_JAL: begin
        pc_we         = 1'b1;
        pc_src        = 2'd1;
        rf_we         = 1'b1;
        wb_sel        = 2'd2;
        instr_retired = 1'b1;
        state_next    = S_FETCH;
      end

      // PC takes the live ALU sum, so rd==rs1 cannot corrupt the jump target.
      S_JALR: begin
        alu_src_b     = 2'd1;
        pc_we         = 1'b1;
        pc_src        = 2'd2;
        rf_we         = 1'b1;
        wb_sel        = 2'd2;
        instr_retired = 1'b1;
        state_next    = S_FETCH;
      end

      S_TRAP: state_next = S_TRAP;

      default: begin
        state_next = S_TRAP;
        cause_next = CAUSE_ILLEGAL;
      end
    endcase

    if (!rst) begin
      pc_we         = 1'b0;
      oldpc_we      = 1'b0;
      ir_we         = 1'b0;
      mdr_we        = 1'b0;
      mem_en        = 1'b0;
      rf_we         = 1'b0;
      instr_retired = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction expected cycle scripts checked every cycle,
// plus literal latency/trap/reset expectations.
module tb_mc_control_fsm;

  localparam int WL = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0, mem_ready = 1'b0;
  logic       pc_we, oldpc_we, ir_we, mdr_we, mem_en, mem_wr, mem_addr_sel, rf_we;
  logic       instr_retired, halted;
  logic [1:0] pc_src, wb_sel, alu_src_a, alu_src_b, alu_op, trap_cause;
  logic [2:0] imm_sel;
  logic [3:0] state;

  mc_control_fsm #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_src(pc_src), .oldpc_we(oldpc_we), .ir_we(ir_we), .mdr_we(mdr_we),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr_sel(mem_addr_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_sel(imm_sel), .instr_retired(instr_retired), .halted(halted),
    .trap_cause(trap_cause), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       oldpc_we, ir_we, mdr_we, mem_en, mem_wr, mem_addr_sel, rf_we;
    logic [1:0] wb_sel, a, b, op;
    logic [2:0] imm;
    logic       ret, halted;
    logic [1:0] cause;
  } rec_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } lit_t;

  rec_t  exp_q[$];
  string tag_q[$];
  lit_t  lit_q[$];
  rec_t  exp_r, act_r;
  lit_t  lit_r;
  string tag_s;
  int checks = 0, errors = 0;
  int cyc_cnt = 0, retire_cnt = 0, last_retire_cyc = -1;
  int start_cyc = 0, exp_retires = 0;

  // Compare process: every cycle a script entry exists, plus any queued literal checks.
  always @(negedge clk) begin
    cyc_cnt++;
    if (instr_retired === 1'b1) begin
      retire_cnt++;
      last_retire_cyc = cyc_cnt;
    end
    if (exp_q.size() != 0) begin
      exp_r = exp_q.pop_front();
      tag_s = tag_q.pop_front();
      act_r = '{st: state, pc_we: pc_we, pc_src: pc_src, oldpc_we: oldpc_we, ir_we: ir_we,
                mdr_we: mdr_we, mem_en: mem_en, mem_wr: mem_wr, mem_addr_sel: mem_addr_sel,
                rf_we: rf_we, wb_sel: wb_sel, a: alu_src_a, b: alu_src_b, op: alu_op,
                imm: imm_sel, ret: instr_retired, halted: halted, cause: trap_cause};
      checks++;
      if (act_r !== exp_r) begin
        errors++;
        $display("[TB] FAIL %s (cycle %0d): got %h required %h", tag_s, cyc_cnt, act_r, exp_r);
      end
    end
    while (lit_q.size() != 0) begin
      lit_r = lit_q.pop_front();
      checks++;
      if (lit_r.act !== lit_r.exp) begin
        errors++;
        $display("[TB] FAIL %s: got %0d required %0d", lit_r.name, lit_r.act, lit_r.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Per-state output expectations, taken from the control table.
  function automatic rec_t base(input logic [3:0] st);
    rec_t r = '0;
    r.st = st;
    return r;
  endfunction

  function automatic rec_t fetch_rec(input logic rdy);
    rec_t r = base(4'd0);
    r.mem_en = 1'b1;
    if (rdy) begin r.ir_we = 1'b1; r.oldpc_we = 1'b1; r.pc_we = 1'b1; end
    return r;
  endfunction

  function automatic rec_t decode_rec(input logic [6:0] opc);
    rec_t r = base(4'd1);
    r.a = 2'd1; r.b = 2'd1;
    case (opc)
      OP_STORE:         r.imm = 3'd1;
      OP_BRANCH:        r.imm = 3'd2;
      OP_LUI, OP_AUIPC: r.imm = 3'd3;
      OP_JAL:           r.imm = 3'd4;
      default:          r.imm = 3'd0;
    endcase
    return r;
  endfunction

  function automatic rec_t trap_rec(input logic [1:0] c);
    rec_t r = base(4'd15);
    r.halted = 1'b1; r.cause = c;
    return r;
  endfunction

  function automatic rec_t gate(input rec_t r0);
    rec_t r = r0;
    r.pc_we = 0; r.oldpc_we = 0; r.ir_we = 0; r.mdr_we = 0; r.mem_en = 0; r.rf_we = 0; r.ret = 0;
    return r;
  endfunction

  function automatic logic is_illegal(input logic [6:0] opc, input logic [2:0] f3);
    case (opc)
      OP_R, OP_IMM, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE, OP_JAL, OP_JALR: return 1'b0;
      OP_BRANCH: return (f3 == 3'b010) || (f3 == 3'b011);
      default:   return 1'b1;
    endcase
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic apply_stimulus(input rec_t r, input logic rdy, input string tag);
    mem_ready = rdy;
    exp_q.push_back(r);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    lit_t l;
    l.name = name; l.act = act; l.exp = exp;
    lit_q.push_back(l);
  endtask

  task automatic do_reset(input rec_t prev);
    rst = 1'b0;
    apply_stimulus(gate(prev), 1'b1, "reset cycle");
    rst = 1'b1;
    check_output("state after reset", 32'(state), 32'd0);
    check_output("trap_cause after reset", 32'(trap_cause), 32'd0);
  endtask

  task automatic run_instr(input string name, input logic [6:0] opc, input logic [2:0] f3,
                           input logic z, input logic lt, input logic ltu,
                           input int fetch_w, input int mem_w, input int exp_lat);
    rec_t r;
    opcode = opc; funct3 = f3; alu_zero = z; alu_lt = lt; alu_ltu = ltu;
    start_cyc = cyc_cnt;
    for (int i = 0; i < fetch_w; i++) apply_stimulus(fetch_rec(1'b0), 1'b0, {name, " fetch wait"});
    apply_stimulus(fetch_rec(1'b1), 1'b1, {name, " fetch"});
    apply_stimulus(decode_rec(opc), 1'b1, {name, " decode"});
    if (is_illegal(opc, f3)) begin
      for (int i = 0; i < 20; i++) apply_stimulus(trap_rec(2'd1), 1'b1, {name, " trap"});
      check_output({name, " trap_cause"}, 32'(trap_cause), 32'd1);
      check_output({name, " halted"}, 32'(halted), 32'd1);
      return;
    end
    case (opc)
      OP_R, OP_IMM, OP_LUI, OP_AUIPC: begin
        if (opc == OP_R) begin
          r = base(4'd2); r.op = 2'd2;
        end else if (opc == OP_IMM) begin
          r = base(4'd3); r.b = 2'd1; r.op = 2'd3;
        end else begin
          r = base(4'd4); r.b = 2'd1; r.imm = 3'd3;
          r.a = (opc == OP_LUI) ? 2'd2 : 2'd1;
        end
        apply_stimulus(r, 1'b1, {name, " exec"});
        r = base(4'd9); r.rf_we = 1'b1; r.ret = 1'b1;
        apply_stimulus(r, 1'b1, {name, " alu wb"});
      end
      OP_LOAD, OP_STORE: begin
        r = base(4'd5); r.b = 2'd1; r.imm = (opc == OP_STORE) ? 3'd1 : 3'd0;
        apply_stimulus(r, 1'b1, {name, " mem addr"});
        r = base((opc == OP_STORE) ? 4'd8 : 4'd6);
        r.mem_en = 1'b1; r.mem_addr_sel = 1'b1; r.mem_wr = (opc == OP_STORE);
        for (int i = 0; i < mem_w; i++) apply_stimulus(r, 1'b0, {name, " mem wait"});
        if (opc == OP_STORE) r.ret = 1'b1;
        else r.mdr_we = 1'b1;
        apply_stimulus(r, 1'b1, {name, " mem access"});
        if (opc == OP_LOAD) begin
          r = base(4'd7); r.rf_we = 1'b1; r.wb_sel = 2'd1; r.ret = 1'b1;
          apply_stimulus(r, 1'b1, {name, " mem wb"});
        end
      end
      OP_BRANCH: begin
        r = base(4'd10); r.op = 2'd1; r.ret = 1'b1;
        if (taken(f3, z, lt, ltu)) begin r.pc_we = 1'b1; r.pc_src = 2'd1; end
        apply_stimulus(r, 1'b1, {name, " branch"});
      end
      default: begin
        r = base((opc == OP_JAL) ? 4'd11 : 4'd12);
        r.pc_we = 1'b1; r.rf_we = 1'b1; r.wb_sel = 2'd2; r.ret = 1'b1;
        if (opc == OP_JAL) r.pc_src = 2'd1;
        else begin r.pc_src = 2'd2; r.b = 2'd1; end
        apply_stimulus(r, 1'b1, {name, " jump"});
      end
    endcase
    exp_retires++;
    check_output({name, " latency"}, 32'(last_retire_cyc - start_cyc), 32'(exp_lat));
  endtask

  initial begin
    rec_t r;
    @(posedge clk);
    #1;
    apply_stimulus(gate(fetch_rec(1'b0)), 1'b0, "in reset");
    apply_stimulus(gate(fetch_rec(1'b0)), 1'b0, "in reset");
    rst = 1'b1;
    check_output("state out of reset", 32'(state), 32'd0);

    run_instr("ADD",   OP_R,      3'd0, 0, 0, 0, 0, 0, 4);
    run_instr("LW",    OP_LOAD,   3'd2, 0, 0, 0, 0, 3, 8);
    run_instr("BEQ",   OP_BRANCH, 3'd0, 1, 0, 0, 0, 0, 3);
    run_instr("BNE",   OP_BRANCH, 3'd1, 1, 0, 0, 0, 0, 3);
    run_instr("BLT",   OP_BRANCH, 3'd4, 0, 1, 0, 0, 0, 3);
    run_instr("BGE",   OP_BRANCH, 3'd5, 0, 1, 0, 0, 0, 3);
    run_instr("BLTU",  OP_BRANCH, 3'd6, 0, 0, 0, 0, 0, 3);
    run_instr("BGEU",  OP_BRANCH, 3'd7, 0, 0, 0, 0, 0, 3);
    run_instr("SW",    OP_STORE,  3'd2, 0, 0, 0, 0, 0, 4);
    run_instr("SWw",   OP_STORE,  3'd2, 0, 0, 0, 0, 2, 6);
    run_instr("LWfast",OP_LOAD,   3'd2, 0, 0, 0, 0, 0, 5);
    run_instr("ADDI",  OP_IMM,    3'd0, 0, 0, 0, 0, 0, 4);
    run_instr("LUI",   OP_LUI,    3'd0, 0, 0, 0, 0, 0, 4);
    run_instr("AUIPC", OP_AUIPC,  3'd0, 0, 0, 0, 0, 0, 4);
    run_instr("JAL",   OP_JAL,    3'd0, 0, 0, 0, 0, 0, 3);
    run_instr("JALR",  OP_JALR,   3'd0, 0, 0, 0, 0, 0, 3);
    run_instr("ADDlimit", OP_R,   3'd0, 0, 0, 0, WL - 1, 0, WL + 3);

    run_instr("ILL7F", 7'h7F, 3'd0, 0, 0, 0, 0, 0, 0);
    do_reset(trap_rec(2'd1));
    run_instr("BRf3",  OP_BRANCH, 3'd3, 0, 0, 0, 0, 0, 0);
    do_reset(trap_rec(2'd1));

    opcode = OP_R; funct3 = 3'd0;
    for (int i = 0; i < WL; i++) apply_stimulus(fetch_rec(1'b0), 1'b0, "timeout fetch");
    for (int i = 0; i < 5; i++) apply_stimulus(trap_rec(2'd2), 1'b1, "timeout trap");
    check_output("timeout trap_cause", 32'(trap_cause), 32'd2);
    check_output("timeout state", 32'(state), 32'd15);
    do_reset(trap_rec(2'd2));

    opcode = OP_STORE; funct3 = 3'd2;
    apply_stimulus(fetch_rec(1'b1), 1'b1, "abort fetch");
    apply_stimulus(decode_rec(OP_STORE), 1'b1, "abort decode");
    r = base(4'd5); r.b = 2'd1; r.imm = 3'd1;
    apply_stimulus(r, 1'b1, "abort mem addr");
    r = base(4'd8); r.mem_en = 1'b1; r.mem_wr = 1'b1; r.mem_addr_sel = 1'b1; r.ret = 1'b1;
    rst = 1'b0;
    apply_stimulus(gate(r), 1'b1, "abort in mem_wr");
    rst = 1'b1;
    check_output("abort state", 32'(state), 32'd0);
    run_instr("ADDafter", OP_R, 3'd0, 0, 0, 0, 0, 0, 4);

    check_output("retire count", 32'(retire_cnt), 32'(exp_retires));
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
